// File: rtl/lsu_stage.sv
// lsu_stage: load/store stage issuing at most one req/gnt/rvalid bus transaction per op
module lsu_stage #(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              l_valid_i,
    output logic              l_ready_o,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   res_i,
    input  logic [XLEN-1:0]   src2_i,
    output logic              l_valid_o,
    input  logic              l_ready_i,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [STRB_W-1:0] mem_wstrb_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_err_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t            r_state, w_next;
    logic              r_ld, r_st, r_mis, r_berr;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_addr, r_src2, r_wb;
    logic              w_acc, w_mem_op, w_bad, w_ack, w_req, w_wr;
    logic [1:0]        w_off;
    logic [XLEN-1:0]   w_shift, w_load;

    assign w_acc    = l_valid_i && (r_state == IDLE);
    assign w_mem_op = is_load_i || is_store_i;
    assign w_bad    = (is_load_i && is_store_i)
                   || (is_load_i && (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11))
                   || (is_store_i && funct3_i > 3'b010)
                   || (w_mem_op && ((funct3_i[1:0] == 2'b01 && res_i[0])
                                 || (funct3_i[1:0] == 2'b10 && res_i[1:0] != 2'b00)));
    assign w_ack    = mem_rvalid_i && (r_state == WAIT || (r_state == REQ && mem_gnt_i));
    assign w_off    = r_addr[1:0];
    assign w_shift  = mem_rdata_i >> {w_off, 3'b000};
    assign w_load   = (r_f3[1:0] == 2'b00) ? {{(XLEN-8){~r_f3[2] & w_shift[7]}}, w_shift[7:0]}
                    : (r_f3[1:0] == 2'b01) ? {{(XLEN-16){~r_f3[2] & w_shift[15]}}, w_shift[15:0]}
                    : w_shift;

    assign w_req       = (r_state == REQ);
    assign w_wr        = w_req && r_st;
    assign l_ready_o   = (r_state == IDLE);
    assign l_valid_o   = (r_state == DONE);
    assign wb_data_o   = r_wb;
    assign misalign_o  = r_mis;
    assign bus_err_o   = r_berr;
    assign mem_req_o   = w_req;
    assign mem_we_o    = w_wr;
    assign mem_addr_o  = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign mem_wdata_o = !w_wr ? '0
                       : (r_f3[1:0] == 2'b00) ? {STRB_W{r_src2[7:0]}}
                       : (r_f3[1:0] == 2'b01) ? {(STRB_W/2){r_src2[15:0]}}
                       : r_src2;
    assign mem_wstrb_o = !w_wr ? '0
                       : (r_f3[1:0] == 2'b00) ? STRB_W'(1) << w_off
                       : (r_f3[1:0] == 2'b01) ? STRB_W'(3) << w_off
                       : '1;

    // state register; async reset drops any in-flight request immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next-state: bad accesses skip the bus, gnt+rvalid together shortcut WAIT
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (l_valid_i) w_next = (w_mem_op && !w_bad) ? REQ : DONE;
            REQ:     if (mem_gnt_i) w_next = mem_rvalid_i ? DONE : WAIT;
            WAIT:    if (mem_rvalid_i) w_next = DONE;
            DONE:    if (l_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // op capture on accept, response capture on ack
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ld   <= 1'b0;
            r_st   <= 1'b0;
            r_f3   <= '0;
            r_addr <= '0;
            r_src2 <= '0;
            r_wb   <= '0;
            r_mis  <= 1'b0;
            r_berr <= 1'b0;
        end else if (w_acc) begin
            r_ld   <= is_load_i;
            r_st   <= is_store_i;
            r_f3   <= funct3_i;
            r_addr <= res_i;
            r_src2 <= src2_i;
            r_wb   <= w_mem_op ? '0 : res_i;
            r_mis  <= w_bad;
            r_berr <= 1'b0;
        end else if (w_ack) begin
            r_wb   <= r_ld ? w_load : '0;
            r_berr <= mem_err_i;
        end
    end
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: randomized and directed check of lsu_stage against a behavioural model
module tb_lsu_stage;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        l_valid_i = 1'b0, l_ready_o, is_load_i = 1'b0, is_store_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] res_i = '0, src2_i = '0;
    logic        l_valid_o, l_ready_i = 1'b0, misalign_o, bus_err_o;
    logic [31:0] wb_data_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
    logic [3:0]  mem_wstrb_o;

    int n_cmp = 0, n_bad = 0;
    logic        active = 1'b0;
    logic        e_bus, e_we, e_mis, e_berr;
    logic [31:0] e_addr, e_wdata, e_wb;
    logic [3:0]  e_wstrb;
    logic [31:0] last_wb, last_wdata, last_addr;
    logic [3:0]  last_wstrb;
    logic        last_mis, last_berr;

    always #5 clk_i = ~clk_i;

    lsu_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .l_valid_i(l_valid_i), .l_ready_o(l_ready_o),
        .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
        .res_i(res_i), .src2_i(src2_i), .l_valid_o(l_valid_o), .l_ready_i(l_ready_i),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // expected behaviour of one op, from access size, legality and byte lanes
    task automatic model(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] src2,
                         input logic [31:0] rdata, input logic err);
        int size, off;
        logic legal;
        logic [31:0] mask, v;
        size  = 1 << f3[1:0];
        off   = int'(res[1:0]);
        legal = ld ^ st;
        if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) legal = 1'b0;
        if (st && f3 > 3'd2) legal = 1'b0;
        if (size <= 4 && (int'(res[1:0]) % size) != 0) legal = 1'b0;
        e_bus   = (ld || st) && legal;
        e_mis   = (ld || st) && !legal;
        e_we    = e_bus && st;
        e_addr  = res & ~32'h3;
        e_wstrb = (st && size <= 4) ? 4'(((1 << size) - 1) << off) : 4'h0;
        e_wdata = '0;
        if (st && size <= 4)
            for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = src2[8*(i % size) +: 8];
        mask = (size >= 4) ? 32'hFFFF_FFFF : (32'h1 << (8*size)) - 32'h1;
        v    = (rdata >> (8*off)) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        e_wb   = !(ld || st) ? res : (e_bus && ld) ? v : 32'h0;
        e_berr = e_bus && err;
    endtask

    // every cycle: bus fields while requesting, write-back fields while valid
    always @(negedge clk_i) begin
        if (active && !rst_i) begin
            if (mem_req_o) begin
                chk("mem_req", {31'b0, mem_req_o}, {31'b0, e_bus});
                chk("mem_addr", mem_addr_o, e_addr);
                chk("mem_we", {31'b0, mem_we_o}, {31'b0, e_we});
                chk("mem_wdata", mem_wdata_o, e_wdata);
                chk("mem_wstrb", {28'b0, mem_wstrb_o}, {28'b0, e_wstrb});
            end
            if (l_valid_o) begin
                chk("wb_data", wb_data_o, e_wb);
                chk("misalign", {31'b0, misalign_o}, {31'b0, e_mis});
                chk("bus_err", {31'b0, bus_err_o}, {31'b0, e_berr});
                chk("ready_in_done", {31'b0, l_ready_o}, 32'h0);
            end
        end
    end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] res, input logic [31:0] src2,
                          input logic [31:0] rdata, input logic err,
                          input int gd, input int rd, input int bp);
        model(ld, st, f3, res, src2, rdata, err);
        chk("ready_idle", {31'b0, l_ready_o}, 32'h1);
        l_valid_i = 1'b1; is_load_i = ld; is_store_i = st; funct3_i = f3;
        res_i = res; src2_i = src2;
        step();
        l_valid_i = 1'b0; is_load_i = 1'($urandom); is_store_i = 1'($urandom);
        funct3_i = 3'($urandom); res_i = $urandom; src2_i = $urandom;
        if (e_bus) begin
            for (int i = 0; i < gd; i++) begin
                chk("req_hold", {31'b0, mem_req_o}, 32'h1);
                step();
            end
            chk("req_at_gnt", {31'b0, mem_req_o}, 32'h1);
            last_addr = mem_addr_o; last_wdata = mem_wdata_o; last_wstrb = mem_wstrb_o;
            mem_gnt_i = 1'b1;
            if (rd == 0) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
            end
            step();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom; mem_err_i = 1'($urandom);
            if (rd > 0) begin
                chk("wait_no_req", {31'b0, mem_req_o}, 32'h0);
                for (int i = 1; i < rd; i++) step();
                mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
                step();
                mem_rvalid_i = 1'b0; mem_rdata_i = $urandom; mem_err_i = 1'($urandom);
            end
        end
        chk("valid_latency", {31'b0, l_valid_o}, 32'h1);
        last_wb = wb_data_o; last_mis = misalign_o; last_berr = bus_err_o;
        for (int i = 0; i < bp; i++) begin
            mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom; mem_err_i = 1'($urandom);
            step();
        end
        mem_rvalid_i = 1'b0;
        l_ready_i = 1'b1;
        step();
        l_ready_i = 1'b0;
        chk("ready_after", {31'b0, l_ready_o}, 32'h1);
        chk("valid_drop", {31'b0, l_valid_o}, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ld, st;
        logic [2:0] f3;
        int kind;
        #22;
        chk("rst_ready", {31'b0, l_ready_o}, 32'h1);
        chk("rst_valid", {31'b0, l_valid_o}, 32'h0);
        chk("rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_wb", wb_data_o, 32'h0);
        chk("rst_flags", {30'b0, misalign_o, bus_err_o}, 32'h0);
        chk("rst_bus", mem_addr_o | mem_wdata_o | {28'b0, mem_wstrb_o} | {31'b0, mem_we_o}, 32'h0);
        step();
        rst_i = 1'b0;
        step();
        active = 1'b1;

        run_op(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        chk("alu_lit", last_wb, 32'h1234_5678);
        run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'hAB00_0000, 1'b0, 2, 3, 1);
        chk("lb_lit", last_wb, 32'hFFFF_FFAB);
        chk("lb_addr_lit", last_addr, 32'h8000_0000);
        chk("lb_wstrb_lit", {28'b0, last_wstrb}, 32'h0);
        run_op(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h9876_0000, 1'b0, 1, 1, 0);
        chk("lhu_lit", last_wb, 32'h0000_9876);
        run_op(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00C5, 32'h0, 1'b1, 3, 2, 0);
        chk("sb_wdata_lit", last_wdata, 32'hC5C5_C5C5);
        chk("sb_wstrb_lit", {28'b0, last_wstrb}, 32'h2);
        chk("sb_err_lit", {31'b0, last_berr}, 32'h1);
        chk("sb_wb_lit", last_wb, 32'h0);
        run_op(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        chk("lw_mis_lit", {31'b0, last_mis}, 32'h1);
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 5);
        chk("lw_gnt_rvalid_lit", last_wb, 32'hCAFE_F00D);
        run_op(1'b1, 1'b1, 3'b000, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        chk("ld_st_both_lit", {31'b0, last_mis}, 32'h1);

        // reset while a request is outstanding
        active = 1'b0;
        l_valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010;
        res_i = 32'h8000_0010;
        step();
        l_valid_i = 1'b0;
        step();
        chk("pre_rst_req", {31'b0, mem_req_o}, 32'h1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_mid_ready", {31'b0, l_ready_o}, 32'h1);
        chk("rst_mid_valid", {31'b0, l_valid_o}, 32'h0);
        step();
        rst_i = 1'b0;
        step();
        active = 1'b1;

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 7));
            ld = (kind inside {1, 2, 3, 7});
            st = (kind inside {4, 5, 6, 7});
            f3 = $urandom_range(0, 1) ? 3'($urandom) : 3'($urandom_range(0, 2));
            run_op(ld, st, f3, $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store stage sitting directly downstream of the execute stage and upstream of write-back.
- Takes the execute result (effective address or ALU result), store data and the op class, then performs at most one data-memory transaction over a req/gnt/rvalid bus.
- Presents the write-back value with a valid/ready handshake.
- Non-memory ops pass through with one cycle of latency.

Parameters:
- XLEN, 32, datapath and address width.
- STRB_W, XLEN/8, byte-strobe width (4 at default).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- l_valid_i  in  1  execute stage presents an op.
- l_ready_o  out  1  stage can accept an op.
- is_load_i  in  1  op is a load.
- is_store_i  in  1  op is a store.
- funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- res_i  in  XLEN  execute result; effective address when is_load_i/is_store_i.
- src2_i  in  XLEN  store data.
- l_valid_o  out  1  write-back data valid.
- l_ready_i  in  1  write-back accepts.
- wb_data_o  out  XLEN  loaded value or passed-through res_i.
- misalign_o  out  1  access was misaligned or had an illegal funct3; qualified by l_valid_o.
- bus_err_o  out  1  memory returned an error; qualified by l_valid_o.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  XLEN  word-aligned address (res_i with bits [1:0] forced to 00).
- mem_wdata_o  out  XLEN  store data, lane-replicated.
- mem_wstrb_o  out  STRB_W  byte strobes (all 0 for reads).
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  response/ack; read data valid for loads.
- mem_rdata_i  in  XLEN  read data.
- mem_err_i  in  1  error, qualified by mem_rvalid_i.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset forces IDLE.
- Reset values: all outputs 0 except l_ready_o=1. Internal op registers are cleared.
- l_ready_o=1 only in IDLE. A transfer occurs when l_valid_i && l_ready_o; all inputs are registered on that edge.
- IDLE, on accept, chooses the next state:
  - Neither is_load_i nor is_store_i: wb_data<=res_i, go to DONE. l_valid_o rises the next cycle (1-cycle latency).
  - Load/store that is misaligned or illegal: misalign<=1, wb_data<=0, go to DONE; no bus request is issued.
    - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
    - Illegal funct3: 011, 110, 111 for loads; anything above 010 for stores.
  - Otherwise: go to REQ.
  - is_load_i and is_store_i both 1: treated as illegal (misalign=1).
- REQ: mem_req_o=1. mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o stay constant until mem_gnt_i.
  - On gnt, go to WAIT.
  - gnt and rvalid in the same cycle: go straight to DONE, capturing the response.
- WAIT: mem_req_o=0. On mem_rvalid_i, capture the response (data/err) and go to DONE. No timeout.
- DONE: l_valid_o=1 with wb_data_o, misalign_o and bus_err_o held stable. Go to IDLE when l_ready_i.
- Total latency for an aligned access with gnt at cycle k and rvalid at cycle m: DONE at m+1.
- Store lanes, with off=addr[1:0]:
  - B: wstrb=0001<<off, wdata={4{src2[7:0]}}.
  - H: wstrb=0011<<off, wdata={2{src2[15:0]}}.
  - W: wstrb=1111, wdata=src2.
- Load extract: rdata>>(8*off), then sign-extend (B, H) or zero-extend (BU, HU) from 8/16 bits; W is unmodified.
- Store write-back: wb_data_o=0. bus_err_o=mem_err_i captured at ack.
- mem_rvalid_i outside REQ/WAIT is ignored.
- Asynchronous reset mid-transaction drops mem_req_o immediately and discards the op. The memory side shares the same reset.
- No pipelining: at most one outstanding bus transaction.

Test Plan:
- ALU pass-through: accept res_i=0x1234_5678 with no load/store, l_ready_i=1 -> l_valid_o the next cycle with wb_data_o=0x1234_5678; l_ready_o returns to 1 the cycle after.
- LB sign-extend: addr=0x8000_0003, rdata=0xAB00_0000, gnt after 2 cycles, rvalid 3 cycles later -> mem_addr_o=0x8000_0000, mem_wstrb_o=0000, wb_data_o=0xFFFF_FFAB.
- LHU: addr=0x8000_0002, rdata=0x9876_0000 -> wb_data_o=0x0000_9876.
- SB: addr=0x8000_0001, src2=0x0000_00C5 -> mem_we_o=1, wstrb=0010, wdata=0xC5C5_C5C5, stable while gnt is low. On rvalid with mem_err_i=1 -> bus_err_o=1, wb_data_o=0.
- Misaligned LW: addr=0x8000_0002 -> mem_req_o never asserts, l_valid_o one cycle after accept, misalign_o=1.
- Backpressure and reset: hold l_ready_i=0 for 5 cycles in DONE -> outputs stable and l_ready_o=0. Separately, assert rst_i while in REQ -> mem_req_o=0 in the same cycle, l_ready_o=1, l_valid_o=0.
